// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port bundle: writeback handshake, load issue/return and RF write/busy outputs.
interface rf_write_arbiter_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        ld_issue;
  logic [2:0]  ld_reg;
  logic [15:0] i_ldst_rddata;
  logic        RFWrite;
  logic [2:0]  regw;
  logic [15:0] dataw;
  logic [7:0]  busy;

  modport slave (
    input  wb_valid, wb_reg, wb_data, ld_issue, ld_reg, i_ldst_rddata,
    output wb_ready, RFWrite, regw, dataw, busy
  );

  modport master (
    output wb_valid, wb_reg, wb_data, ld_issue, ld_reg, i_ldst_rddata,
    input  wb_ready, RFWrite, regw, dataw, busy
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single RF write port between a buffered writeback stream and
// unstallable load returns; exports a per-register pending-write scoreboard.
module rf_write_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  rf_write_arbiter_if.slave   bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [2:0]  rg;
    logic [15:0] data;
  } wb_entry_t;

  wb_entry_t             mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [LD_LATENCY-1:0] ld_v;
  logic [2:0]            ld_r [LD_LATENCY];
  logic                  ld_due_c;
  logic                  push_c;
  logic                  pop_c;
  logic [7:0]            busy_c;

  assign bus.wb_ready = (count < CW'(DEPTH));
  assign ld_due_c     = ld_v[LD_LATENCY-1];
  assign push_c       = bus.wb_valid && bus.wb_ready;
  assign pop_c        = !ld_due_c && (count != '0);

  // Load tracker: one stage per cycle of memory latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_v <= '0;
      for (int unsigned i = 0; i < LD_LATENCY; i++) ld_r[i] <= 3'd0;
    end else begin
      ld_v[0] <= bus.ld_issue;
      ld_r[0] <= bus.ld_reg;
      for (int unsigned i = 1; i < LD_LATENCY; i++) begin
        ld_v[i] <= ld_v[i-1];
        ld_r[i] <= ld_r[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= '{rg: bus.wb_reg, data: bus.wb_data};
  end

  // Pointers and occupancy; a push and a pop in one cycle leave count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_c) - CW'(pop_c);
    end
  end

  // Granted write is registered; address and data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.RFWrite <= 1'b0;
      bus.regw    <= 3'd0;
      bus.dataw   <= 16'd0;
    end else begin
      bus.RFWrite <= ld_due_c || pop_c;
      if (ld_due_c) begin
        bus.regw  <= ld_r[LD_LATENCY-1];
        bus.dataw <= bus.i_ldst_rddata;
      end else if (pop_c) begin
        bus.regw  <= mem[rd_ptr].rg;
        bus.dataw <= mem[rd_ptr].data;
      end
    end
  end

  // Scoreboard is derived from state only, so it follows the edge after issue/enqueue.
  always_comb begin
    busy_c = '0;
    for (int unsigned i = 0; i < LD_LATENCY; i++) begin
      if (ld_v[i]) busy_c[ld_r[i]] = 1'b1;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) busy_c[mem[rd_ptr + PW'(i)].rg] = 1'b1;
    end
  end

  assign bus.busy = busy_c;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (DEPTH=2, LD_LATENCY=1): vector table plus reset/streaming sequences.
module tb_rf_write_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  rf_write_arbiter_if bus ();

  rf_write_arbiter #(.DEPTH(2), .LD_LATENCY(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        wv;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic        li;
    logic [2:0]  lr;
    logic [15:0] rd;
    logic        we;
    logic [2:0]  er;
    logic [15:0] ed;
    logic [7:0]  eb;
    logic        erdy;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic wv, logic [2:0] wr, logic [15:0] wd,
                              logic li, logic [2:0] lr, logic [15:0] rd,
                              logic we, logic [2:0] er, logic [15:0] ed,
                              logic [7:0] eb, logic erdy);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wr = wr; v.wd = wd; v.li = li; v.lr = lr; v.rd = rd;
    v.we = we; v.er = er; v.ed = ed; v.eb = eb; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wv, input logic [2:0] wr, input logic [15:0] wd,
                       input logic li, input logic [2:0] lr, input logic [15:0] rd);
    bus.wb_valid      = wv;
    bus.wb_reg        = wr;
    bus.wb_data       = wd;
    bus.ld_issue      = li;
    bus.ld_reg        = lr;
    bus.i_ldst_rddata = rd;
  endtask

  task automatic chk_all(input string tag, input logic we, input logic [2:0] er,
                         input logic [15:0] ed, input logic [7:0] eb, input logic erdy);
    chk({tag, ".RFWrite"},  16'(bus.RFWrite),  16'(we));
    chk({tag, ".regw"},     16'(bus.regw),     16'(er));
    chk({tag, ".dataw"},    bus.dataw,         ed);
    chk({tag, ".busy"},     16'(bus.busy),     16'(eb));
    chk({tag, ".wb_ready"}, 16'(bus.wb_ready), 16'(erdy));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

    // reset with activity, then single WB and load priority
    vecs[0]  = mk(0,1,3'd3,16'hFFFF,1,3'd2,16'hABCD, 0,3'd0,16'h0000,8'h00,1);
    vecs[1]  = mk(1,0,3'd0,16'h0000,0,3'd0,16'h0000, 0,3'd0,16'h0000,8'h00,1);
    vecs[2]  = mk(1,1,3'd3,16'h1234,0,3'd0,16'h0000, 0,3'd0,16'h0000,8'h08,1);
    vecs[3]  = mk(1,0,3'd0,16'h0000,0,3'd0,16'h0000, 1,3'd3,16'h1234,8'h00,1);
    vecs[4]  = mk(1,0,3'd0,16'h0000,0,3'd0,16'h0000, 0,3'd3,16'h1234,8'h00,1);
    vecs[5]  = mk(1,1,3'd2,16'hAAAA,1,3'd5,16'h0000, 0,3'd3,16'h1234,8'h24,1);
    vecs[6]  = mk(1,0,3'd0,16'h0000,0,3'd0,16'hBEEF, 1,3'd5,16'hBEEF,8'h04,1);
    vecs[7]  = mk(1,0,3'd0,16'h0000,0,3'd0,16'h0000, 1,3'd2,16'hAAAA,8'h00,1);
    vecs[8]  = mk(1,0,3'd0,16'h0000,0,3'd0,16'h0000, 0,3'd2,16'hAAAA,8'h00,1);
    // six back-to-back loads to r6 while three wb requests are offered
    vecs[9]  = mk(1,1,3'd1,16'h1111,1,3'd6,16'h0000, 0,3'd2,16'hAAAA,8'h42,1);
    vecs[10] = mk(1,1,3'd3,16'h3333,1,3'd6,16'h1001, 1,3'd6,16'h1001,8'h4A,0);
    vecs[11] = mk(1,1,3'd4,16'h4444,1,3'd6,16'h1002, 1,3'd6,16'h1002,8'h4A,0);
    vecs[12] = mk(1,1,3'd4,16'h4444,1,3'd6,16'h1003, 1,3'd6,16'h1003,8'h4A,0);
    vecs[13] = mk(1,1,3'd4,16'h4444,1,3'd6,16'h1004, 1,3'd6,16'h1004,8'h4A,0);
    vecs[14] = mk(1,1,3'd4,16'h4444,1,3'd6,16'h1005, 1,3'd6,16'h1005,8'h4A,0);
    vecs[15] = mk(1,1,3'd4,16'h4444,0,3'd0,16'h1006, 1,3'd6,16'h1006,8'h0A,0);
    vecs[16] = mk(1,1,3'd4,16'h4444,0,3'd0,16'h0000, 1,3'd1,16'h1111,8'h08,1);
    vecs[17] = mk(1,1,3'd4,16'h4444,0,3'd0,16'h0000, 1,3'd3,16'h3333,8'h10,1);
    vecs[18] = mk(1,0,3'd0,16'h0000,0,3'd0,16'h0000, 1,3'd4,16'h4444,8'h00,1);
    vecs[19] = mk(1,0,3'd0,16'h0000,0,3'd0,16'h0000, 0,3'd4,16'h4444,8'h00,1);
    // call link to r7, then two loads to r1
    vecs[20] = mk(1,1,3'd7,16'h0042,0,3'd0,16'h0000, 0,3'd4,16'h4444,8'h80,1);
    vecs[21] = mk(1,0,3'd0,16'h0000,1,3'd1,16'h0000, 1,3'd7,16'h0042,8'h02,1);
    vecs[22] = mk(1,0,3'd0,16'h0000,1,3'd1,16'h0A01, 1,3'd1,16'h0A01,8'h02,1);
    vecs[23] = mk(1,0,3'd0,16'h0000,0,3'd0,16'h0A02, 1,3'd1,16'h0A02,8'h00,1);
    vecs[24] = mk(1,0,3'd0,16'h0000,0,3'd0,16'h0000, 0,3'd1,16'h0A02,8'h00,1);
    // two queued entries plus a load in flight, then a reset pulse
    vecs[25] = mk(1,1,3'd2,16'h2222,1,3'd5,16'h0000, 0,3'd1,16'h0A02,8'h24,1);
    vecs[26] = mk(1,1,3'd3,16'h3333,1,3'd6,16'h5555, 1,3'd5,16'h5555,8'h4C,0);
    vecs[27] = mk(0,0,3'd0,16'h0000,0,3'd0,16'h6666, 0,3'd0,16'h0000,8'h00,1);
    vecs[28] = mk(1,0,3'd0,16'h0000,0,3'd0,16'h6666, 0,3'd0,16'h0000,8'h00,1);
    vecs[29] = mk(1,0,3'd0,16'h0000,0,3'd0,16'h6666, 0,3'd0,16'h0000,8'h00,1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      drive(vecs[i].wv, vecs[i].wr, vecs[i].wd, vecs[i].li, vecs[i].lr, vecs[i].rd);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].we, vecs[i].er, vecs[i].ed, vecs[i].eb, vecs[i].erdy);
    end

    // sustained writeback stream: one write per cycle, wb_ready never drops
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b1, 3'(k), 16'h5000 + 16'(k), 1'b0, 3'd0, 16'h0);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d.wb_ready", k), 16'(bus.wb_ready), 16'h1);
      if (k == 0) begin
        chk("stream0.RFWrite", 16'(bus.RFWrite), 16'h0);
      end else begin
        chk($sformatf("stream%0d.RFWrite", k), 16'(bus.RFWrite), 16'h1);
        chk($sformatf("stream%0d.regw", k), 16'(bus.regw), 16'(k - 1));
        chk($sformatf("stream%0d.dataw", k), bus.dataw, 16'h5000 + 16'(k - 1));
      end
    end
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h0);
    @(posedge clk);
    #1;
    chk_all("stream_tail", 1'b1, 3'd4, 16'h5004, 8'h04, 1'b1);

    // asynchronous reset assertion between edges
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 3'd0, 16'h0000, 8'h00, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h7777);
    @(posedge clk);
    #1;
    chk_all("post_async", 1'b0, 3'd0, 16'h0000, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
